// File: rtl/tuner_seq_pkg.sv
// ----------------------------------------------------------------------------
// tuner_seq_pkg
// Shared definitions for the tuner frame sequencer / memory arbiter.
//   - seq_state_t : sequencer state encoding (IDLE, RUN, GAP)
//   - DEF_DATA_W / DEF_ADDR_W : sample-memory widths shared with the memory
//     and FFT blocks
//   - DEF_N_STAGES / DEF_STAGE_IDX_W and stageIdxW() : stage-index width
//     helpers
// ----------------------------------------------------------------------------
package tuner_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2
   } seq_state_t;

   localparam int DEF_DATA_W   = 10;
   localparam int DEF_ADDR_W   = 11;
   localparam int DEF_N_STAGES = 3;

   // Index width for a stage counter; never narrower than one bit so the
   // cur_stage port stays a legal vector.
   function automatic int stageIdxW(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int DEF_STAGE_IDX_W = stageIdxW(DEF_N_STAGES);

endpackage

// File: rtl/tuner_seq_arbiter_wdog.sv
// ----------------------------------------------------------------------------
// tuner_seq_wdog
// Per-stage watchdog for the tuner sequencer. Counts consecutive RUN cycles
// and flags a timeout on the cycle in which the count reaches
// TIMEOUT_CYCLES, so the sequencer leaves RUN exactly TIMEOUT_CYCLES cycles
// after entering it. The counter is held at zero whenever the sequencer is
// not in RUN, which gives the clear-on-entry behaviour (every entry into RUN
// comes from IDLE or GAP).
// Only instantiated when TUNER_SEQ_WDOG_EN is defined.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   run_i      in   sequencer is currently in RUN
//   timeout_o  out  current RUN cycle is the TIMEOUT_CYCLES-th without done
// ----------------------------------------------------------------------------
module tuner_seq_wdog #(
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run_i,
   output logic timeout_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Count RUN cycles; anything other than RUN parks the counter at zero.
   always_comb begin
      cnt_d = '0;
      if (run_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // cnt_q is zero in the first RUN cycle, so TIMEOUT_CYCLES-1 marks the
   // last cycle the stage is allowed to run.
   assign timeout_o = run_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/tuner_seq_arbiter.sv
// ----------------------------------------------------------------------------
// tuner_seq_arbiter
// Frame sequencer and shared sample-memory arbiter for the tuner datapath.
// Runs N_STAGES stages strictly in order, giving the active stage a level
// start and muxing its write port onto the single memory port. A one-cycle
// GAP with no grant separates consecutive stages. Supports single-shot and
// continuous frames, a wrapping 16-bit frame counter and abort.
//
// Optional feature: define TUNER_SEQ_WDOG_EN to compile in a per-stage
// watchdog (tuner_seq_wdog) that aborts a stage after TIMEOUT_CYCLES and
// sets the sticky error flag. Without it, error is tied low.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          begin a frame (only honoured in IDLE)
//   mode_cont      loop back to stage 0 after the last stage
//   abort          return to IDLE, overrides everything
//   stage_start    one-hot level start per stage (registered)
//   stage_done     per-stage completion flag
//   stage_we/addr/wdata  per-stage memory write port, stage i at slice i
//   mem_we/addr/wdata    shared memory port (combinational mux)
//   busy           state != IDLE
//   cur_stage      index of granted / next stage
//   frame_done     one-cycle pulse after the last stage completes
//   frame_count    completed frames, wraps
//   error          sticky watchdog error
// ----------------------------------------------------------------------------
module tuner_seq_arbiter
   import tuner_seq_pkg::*;
#(
   parameter int DATA_W         = DEF_DATA_W,
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int N_STAGES       = DEF_N_STAGES,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start,
   input  logic                                 mode_cont,
   input  logic                                 abort,
   output logic [N_STAGES-1:0]                  stage_start,
   input  logic [N_STAGES-1:0]                  stage_done,
   input  logic [N_STAGES-1:0]                  stage_we,
   input  logic [N_STAGES*ADDR_W-1:0]           stage_addr,
   input  logic [N_STAGES*DATA_W-1:0]           stage_wdata,
   output logic                                 mem_we,
   output logic [ADDR_W-1:0]                    mem_addr,
   output logic [DATA_W-1:0]                    mem_wdata,
   output logic                                 busy,
   output logic [stageIdxW(N_STAGES)-1:0]       cur_stage,
   output logic                                 frame_done,
   output logic [15:0]                          frame_count,
   output logic                                 error
);

   localparam int                IDX_W = stageIdxW(N_STAGES);
   localparam logic [IDX_W-1:0]  LAST  = IDX_W'(N_STAGES - 1);

   seq_state_t           state_q, state_d;
   logic [IDX_W-1:0]     cur_stage_q, cur_stage_d;
   logic [N_STAGES-1:0]  stage_start_q, stage_start_d;
   logic                 busy_q, busy_d;
   logic                 frame_done_q, frame_done_d;
   logic [15:0]          frame_count_q, frame_count_d;
   logic                 cur_done;

`ifdef TUNER_SEQ_WDOG_EN
   logic                 wdog_timeout;
   logic                 error_q, error_d;

   tuner_seq_wdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wdog (
      .clk       (clk),
      .rst_n     (rst_n),
      .run_i     (state_q == RUN),
      .timeout_o (wdog_timeout)
   );
`endif

   // Only the granted stage's done is looked at; other bits are don't-care.
   assign cur_done = stage_done[cur_stage_q];

   // Next-state logic. Priority is abort, then done of the granted stage,
   // then watchdog timeout. stage_start and busy are computed from the next
   // state so that they can be registered alongside it.
   always_comb begin
      state_d       = state_q;
      cur_stage_d   = cur_stage_q;
      frame_done_d  = 1'b0;
      frame_count_d = frame_count_q;
`ifdef TUNER_SEQ_WDOG_EN
      error_d       = error_q;
`endif

      if (abort) begin
         state_d     = IDLE;
         cur_stage_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_d     = RUN;
                  cur_stage_d = '0;
`ifdef TUNER_SEQ_WDOG_EN
                  error_d     = 1'b0;
`endif
               end
            end
            RUN: begin
               if (cur_done) begin
                  if (cur_stage_q == LAST) begin
                     frame_done_d  = 1'b1;
                     frame_count_d = frame_count_q + 16'd1;
                     cur_stage_d   = '0;
                     state_d       = mode_cont ? GAP : IDLE;
                  end else begin
                     cur_stage_d = cur_stage_q + IDX_W'(1);
                     state_d     = GAP;
                  end
               end
`ifdef TUNER_SEQ_WDOG_EN
               else if (wdog_timeout) begin
                  error_d     = 1'b1;
                  state_d     = IDLE;
                  cur_stage_d = '0;
               end
`endif
            end
            GAP: begin
               state_d = RUN;
            end
            default: begin
               state_d     = IDLE;
               cur_stage_d = '0;
            end
         endcase
      end

      stage_start_d = '0;
      if (state_d == RUN) begin
         stage_start_d = N_STAGES'(1) << cur_stage_d;
      end
      busy_d = (state_d != IDLE);
   end

   // State and registered-output flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cur_stage_q   <= '0;
         stage_start_q <= '0;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_count_q <= '0;
      end else begin
         state_q       <= state_d;
         cur_stage_q   <= cur_stage_d;
         stage_start_q <= stage_start_d;
         busy_q        <= busy_d;
         frame_done_q  <= frame_done_d;
         frame_count_q <= frame_count_d;
      end
   end

`ifdef TUNER_SEQ_WDOG_EN
   // Sticky watchdog error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         error_q <= 1'b0;
      end else begin
         error_q <= error_d;
      end
   end
   assign error = error_q;
`else
   assign error = 1'b0;
`endif

   // Memory port mux: only a stage in RUN owns the port; GAP and IDLE
   // drive an all-zero write port so nothing reaches memory between stages.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (state_q == RUN) begin
         mem_we    = stage_we[cur_stage_q];
         mem_addr  = stage_addr[int'(cur_stage_q)*ADDR_W +: ADDR_W];
         mem_wdata = stage_wdata[int'(cur_stage_q)*DATA_W +: DATA_W];
      end
   end

   assign stage_start = stage_start_q;
   assign busy        = busy_q;
   assign cur_stage   = cur_stage_q;
   assign frame_done  = frame_done_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_tuner_seq_arbiter.sv
// ----------------------------------------------------------------------------
// tb_tuner_seq_arbiter
// Directed testbench for tuner_seq_arbiter with N_STAGES=3 and
// TIMEOUT_CYCLES=16. Cycle c is the clock period following rising edge c;
// the start request is driven in cycle 0. Inputs are driven and outputs
// sampled on the falling edge. Watchdog scenario is built only when
// TUNER_SEQ_WDOG_EN is defined.
// ----------------------------------------------------------------------------
module tb_tuner_seq_arbiter;

   localparam int DATA_W   = 10;
   localparam int ADDR_W   = 11;
   localparam int N_STAGES = 3;

   logic                       clk;
   logic                       rst_n;
   logic                       start;
   logic                       mode_cont;
   logic                       abort;
   logic [N_STAGES-1:0]        stage_start;
   logic [N_STAGES-1:0]        stage_done;
   logic [N_STAGES-1:0]        stage_we;
   logic [N_STAGES*ADDR_W-1:0] stage_addr;
   logic [N_STAGES*DATA_W-1:0] stage_wdata;
   logic                       mem_we;
   logic [ADDR_W-1:0]          mem_addr;
   logic [DATA_W-1:0]          mem_wdata;
   logic                       busy;
   logic [1:0]                 cur_stage;
   logic                       frame_done;
   logic [15:0]                frame_count;
   logic                       error;

   int vectors     = 0;
   int miscompares = 0;
   int runLen      = 0;
   logic [15:0] expCount = 16'd0;

   tuner_seq_arbiter #(
      .DATA_W         (DATA_W),
      .ADDR_W         (ADDR_W),
      .N_STAGES       (N_STAGES),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .mode_cont   (mode_cont),
      .abort       (abort),
      .stage_start (stage_start),
      .stage_done  (stage_done),
      .stage_we    (stage_we),
      .stage_addr  (stage_addr),
      .stage_wdata (stage_wdata),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .busy        (busy),
      .cur_stage   (cur_stage),
      .frame_done  (frame_done),
      .frame_count (frame_count),
      .error       (error)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stage stub: a stage raises done on the doneAfter-th cycle its start has
   // been high, provided its bit is set in mask.
   task automatic applyStimulus(input int doneAfter, input logic [N_STAGES-1:0] mask);
      if (stage_start != '0) runLen++;
      else runLen = 0;
      stage_done = (runLen == doneAfter) ? (stage_start & mask) : '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; mode_cont = 1'b0; abort = 1'b0;
      stage_done = '0; stage_we = '0; stage_addr = '0; stage_wdata = '0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({stage_start, busy, cur_stage, frame_done, frame_count, error, mem_we} !== 24'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_state: got %h expected 000000",
                  {stage_start, busy, cur_stage, frame_done, frame_count, error, mem_we});
      end
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL idle_after_reset busy: got %b expected 0", busy);
      end
   endtask

   task automatic test_single_shot();
      logic [2:0] expStart;
      logic [1:0] expCur;
      start = 1'b1; mode_cont = 1'b0; runLen = 0; stage_done = '0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         start = (c == 8);   // start while busy must be ignored
         expStart = (c >= 1  && c <= 5)  ? 3'b001 :
                    (c >= 7  && c <= 11) ? 3'b010 :
                    (c >= 13 && c <= 17) ? 3'b100 : 3'b000;
         expCur   = (c >= 6  && c <= 11) ? 2'd1 :
                    (c >= 12 && c <= 17) ? 2'd2 : 2'd0;
         vectors++;
         if (stage_start !== expStart) begin
            miscompares++;
            $display("[TB] FAIL single_start c=%0d: got %b expected %b", c, stage_start, expStart);
         end
         vectors++;
         if (cur_stage !== expCur) begin
            miscompares++;
            $display("[TB] FAIL single_cur c=%0d: got %0d expected %0d", c, cur_stage, expCur);
         end
         vectors++;
         if (frame_done !== (c == 18)) begin
            miscompares++;
            $display("[TB] FAIL single_fdone c=%0d: got %b expected %b", c, frame_done, (c == 18));
         end
         vectors++;
         if (busy !== (c <= 17)) begin
            miscompares++;
            $display("[TB] FAIL single_busy c=%0d: got %b expected %b", c, busy, (c <= 17));
         end
         applyStimulus(5, 3'b111);
      end
      expCount++;
      vectors++;
      if (frame_count !== expCount) begin
         miscompares++;
         $display("[TB] FAIL single_count: got %0d expected %0d", frame_count, expCount);
      end
   endtask

   task automatic test_grant_mux();
      logic        expWe;
      logic [10:0] expAddr;
      logic [9:0]  expData;
      stage_we    = 3'b011;
      stage_addr  = {11'h055, 11'h123, 11'h7FF};
      stage_wdata = {10'h001, 10'h2AA, 10'h155};
      start = 1'b1; runLen = 0; stage_done = '0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 1 || c == 2)      begin expWe = 1'b1; expAddr = 11'h7FF; expData = 10'h155; end
         else if (c == 4 || c == 5) begin expWe = 1'b1; expAddr = 11'h123; expData = 10'h2AA; end
         else if (c == 7 || c == 8) begin expWe = 1'b0; expAddr = 11'h055; expData = 10'h001; end
         else                       begin expWe = 1'b0; expAddr = 11'h000; expData = 10'h000; end
         vectors++;
         if (mem_we !== expWe) begin
            miscompares++;
            $display("[TB] FAIL mux_we c=%0d: got %b expected %b", c, mem_we, expWe);
         end
         vectors++;
         if (mem_addr !== expAddr) begin
            miscompares++;
            $display("[TB] FAIL mux_addr c=%0d: got %h expected %h", c, mem_addr, expAddr);
         end
         vectors++;
         if (mem_wdata !== expData) begin
            miscompares++;
            $display("[TB] FAIL mux_wdata c=%0d: got %h expected %h", c, mem_wdata, expData);
         end
         applyStimulus(2, 3'b111);
      end
      expCount++;
      stage_we = '0;
   endtask

   task automatic test_continuous();
      mode_cont = 1'b1; start = 1'b1; runLen = 0; stage_done = '0;
      for (int c = 1; c <= 37; c++) begin
         @(negedge clk);
         start = 1'b0;
         vectors++;
         if (frame_done !== ((c % 9 == 0) && c <= 36)) begin
            miscompares++;
            $display("[TB] FAIL cont_fdone c=%0d: got %b expected %b", c, frame_done, ((c % 9 == 0) && c <= 36));
         end
         vectors++;
         if (busy !== (c < 36)) begin
            miscompares++;
            $display("[TB] FAIL cont_busy c=%0d: got %b expected %b", c, busy, (c < 36));
         end
         if (c % 9 == 1 && c < 36) begin
            vectors++;
            if (stage_start !== 3'b001) begin
               miscompares++;
               $display("[TB] FAIL cont_restart c=%0d: got %b expected 001", c, stage_start);
            end
         end
         if (c == 27) mode_cont = 1'b0;
         applyStimulus(2, 3'b111);
      end
      expCount += 16'd4;
      vectors++;
      if (frame_count !== expCount) begin
         miscompares++;
         $display("[TB] FAIL cont_count: got %0d expected %0d", frame_count, expCount);
      end
   endtask

   task automatic test_abort();
      bit seen;
      start = 1'b1; mode_cont = 1'b0; runLen = 0; stage_done = '0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         start = 1'b0;
         applyStimulus(2, 3'b111);
      end
      vectors++;
      if (stage_done !== 3'b010) begin
         miscompares++;
         $display("[TB] FAIL abort_setup done: got %b expected 010", stage_done);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      vectors++;
      if ({busy, stage_start, cur_stage, frame_done} !== 7'b0) begin
         miscompares++;
         $display("[TB] FAIL abort_idle: got %b expected 0000000", {busy, stage_start, cur_stage, frame_done});
      end
      vectors++;
      if (frame_count !== expCount) begin
         miscompares++;
         $display("[TB] FAIL abort_count: got %0d expected %0d", frame_count, expCount);
      end
      start = 1'b1; stage_done = '0; runLen = 0;
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if (stage_start !== 3'b001 || cur_stage !== 2'd0) begin
         miscompares++;
         $display("[TB] FAIL abort_restart: got %b/%0d expected 001/0", stage_start, cur_stage);
      end
      seen = 1'b0;
      for (int c = 0; c < 30 && !seen; c++) begin
         applyStimulus(2, 3'b111);
         @(negedge clk);
         seen = frame_done;
      end
      expCount++;
      vectors++;
      if (!seen || frame_count !== expCount) begin
         miscompares++;
         $display("[TB] FAIL abort_followup: seen=%b count %0d expected %0d", seen, frame_count, expCount);
      end
      stage_done = '0;
      @(negedge clk);
   endtask

`ifdef TUNER_SEQ_WDOG_EN
   task automatic test_wdog();
      start = 1'b1; mode_cont = 1'b0; runLen = 0; stage_done = '0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 19) begin
            vectors++;
            if (busy !== 1'b1 || error !== 1'b0 || stage_start !== 3'b010) begin
               miscompares++;
               $display("[TB] FAIL wdog_pre: got busy=%b err=%b start=%b expected 1 0 010", busy, error, stage_start);
            end
         end
         applyStimulus(2, 3'b001);
      end
      vectors++;
      if (busy !== 1'b0 || error !== 1'b1 || frame_done !== 1'b0 || stage_start !== 3'b000) begin
         miscompares++;
         $display("[TB] FAIL wdog_timeout: got busy=%b err=%b fd=%b start=%b expected 0 1 0 000",
                  busy, error, frame_done, stage_start);
      end
      start = 1'b1; stage_done = '0;
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if (error !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL wdog_clear: got err=%b busy=%b expected 0 1", error, busy);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
   endtask
`endif

   task automatic test_async_reset();
      stage_we = 3'b111; start = 1'b1; runLen = 0; stage_done = '0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         start = 1'b0;
         applyStimulus(5, 3'b111);
      end
      vectors++;
      if (mem_we !== 1'b1 || busy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL areset_setup: got we=%b busy=%b expected 1 1", mem_we, busy);
      end
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      vectors++;
      if ({stage_start, busy, cur_stage, frame_done, frame_count, error, mem_we} !== 24'h0) begin
         miscompares++;
         $display("[TB] FAIL areset_values: got %h expected 000000",
                  {stage_start, busy, cur_stage, frame_done, frame_count, error, mem_we});
      end
      @(negedge clk);
      rst_n = 1'b1; stage_we = '0; stage_done = '0;
      expCount = 16'd0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_shot();
      test_grant_mux();
      test_continuous();
      test_abort();
`ifdef TUNER_SEQ_WDOG_EN
      test_wdog();
`endif
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
